inst_axi_rd_bridge: RTL and testbench
=====================================

# inst_axi_rd_bridge

Responder side of the fetch stage's inst_sram interface: takes the fetch address driven by the PC stage, performs a single-beat AXI4 read, and returns the instruction word. It requests a pipeline stall from the controller while a read is outstanding. It sits between the IF stage and the AXI crossbar, replacing a zero-latency instruction SRAM.

## Interface
- ID_W, default 4: AXI ID width.
- AR_ID, default 0: constant ARID value.

- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_i  in  1  controller flush; the in-flight fetch result is discarded.
- inst_sram_en  in  1  fetch enable from IF; ignored for launch decisions (see Operation).
- inst_sram_addr  in  32  fetch virtual address.
- inst_sram_wen  in  4  always 0 from IF; ignored.
- inst_sram_wdata  in  32  ignored.
- inst_sram_rdata  out  32  fetched instruction; valid when stallreq_o=0.
- stallreq_o  out  1  stall request to controller.
- bus_err_o  out  1  one-cycle pulse: the returned beat had RRESP≠OKAY.
- arid  out  ID_W; araddr  out  32; arlen  out  8 (0); arsize  out  3 (3'b010); arburst  out  2 (2'b01); arlock  out  2 (0); arcache  out  4 (0); arprot  out  3 (0).
- arvalid  out  1; arready  in  1.
- rid  in  ID_W (ignored); rdata  in  32; rresp  in  2; rlast  in  1 (ignored); rvalid  in  1; rready  out  1.

## Operation
- FSM states: IDLE, AR, R, DONE.
- Address map: araddr = {3'b000, addr_r[28:0]}. kseg0 and kseg1 both fold to physical; 0xBFC00000 maps to 0x1FC00000.
- IDLE: if !flush_i, latch inst_sram_addr into addr_r and go to AR. If flush_i, stay in IDLE.
- AR: arvalid=1. On arready, go to R. arvalid is never dropped before the handshake, including on flush.
- R: rready=1. On rvalid, capture rdata into rdata_r and rresp≠0 into err_r. Go to DONE, or to IDLE if the discard flag is set; clear discard.
- DONE: for one cycle, inst_sram_rdata=rdata_r and bus_err_o=err_r. Go to IDLE.
- Discard flag: set by flush_i in AR or R, or in the same cycle as the AR→R transition. Cleared on R completion and by reset.
- flush_i in DONE has no effect on that cycle's output. The next IDLE honours it.
- stallreq_o = (state != DONE). It is a pure function of state, never of inst_sram_en or flush_i, so there is no combinational loop through the controller's stall→ren path.
- inst_sram_rdata holds rdata_r in every state; only the DONE value is meaningful.
- inst_sram_en and inst_sram_wen are ignored. The bridge keeps fetching the address currently presented.

## Timing
- Reset: state=IDLE, addr_r=0, rdata_r=0, err_r=0, discard=0; arvalid=0, rready=0, stallreq_o=1, bus_err_o=0, inst_sram_rdata=0.
- Minimum fetch latency, with arready and rvalid both high on first assertion:
  - IDLE at cycle 0.
  - AR at cycle 1.
  - R at cycle 2.
  - DONE at cycle 3.
  - 4 cycles per instruction.
- Each cycle of arready or rvalid wait adds one cycle.
- Exactly one outstanding AR at any time; rready is high only in R.
- rdata is sampled in the rvalid&rready cycle and appears on inst_sram_rdata the following cycle (DONE).
- Reset asserted mid-transaction returns to IDLE immediately. Any late R beat from the old read is the interconnect's responsibility, since the interconnect shares the reset.

## Test plan
- Reset release with inst_sram_addr=0xBFC00000, arready=1, and rvalid returned 1 cycle after AR with rdata=0x3C1DBFC0 → araddr=0x1FC00000, arlen=0, arsize=2; DONE at cycle 3 with inst_sram_rdata=0x3C1DBFC0 and stallreq_o=0 for exactly 1 cycle.
- arready held low 5 cycles → arvalid stays 1 and araddr stays stable throughout; stallreq_o stays 1; completion occurs at cycle 8.
- flush_i pulsed while in R with rvalid delayed 3 cycles → beat is accepted and dropped; no DONE cycle and no stallreq_o=0; next fetch uses the new inst_sram_addr=0x80000180 → araddr=0x00000180.
- flush_i in the AR cycle where arready=1 → discard still applied; exactly one AR handshake, and no second arvalid before R completes.
- rresp=2'b10 with rdata=0xDEADBEEF → bus_err_o=1 and inst_sram_rdata=0xDEADBEEF in DONE; bus_err_o=0 in all other cycles.
- 3 back-to-back fetches with addresses +4 → three DONE cycles 4 cycles apart; no combinational dependence on inst_sram_en (toggling it changes nothing).

Source files
------------

// File: rtl/inst_axi_rd_bridge_if.sv
// AXI4 read-address and read-data channels between the instruction fetch
// bridge (master) and the crossbar (slave).
interface inst_axi_rd_bridge_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [1:0]      arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/inst_axi_rd_bridge.sv
// Turns the zero-latency inst_sram fetch port into single-beat AXI4 reads,
// stalling the pipeline until each instruction word is back.
module inst_axi_rd_bridge #(
  parameter int            ID_W  = 4,
  parameter logic [ID_W-1:0] AR_ID = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        stallreq_o,
  output logic        bus_err_o,
  inst_axi_rd_bridge_if.master axi
);

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        discard_q, discard_d;
  logic        arvalid_d, rready_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    discard_d = discard_q;
    arvalid_d = 1'b0;
    rready_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush_i) begin
          addr_d  = inst_sram_addr;
          state_d = AR;
        end
      end
      // arvalid must stay up until the handshake even when flushed; the flush
      // is remembered and the returning beat dropped instead.
      AR: begin
        arvalid_d = 1'b1;
        if (flush_i) discard_d = 1'b1;
        if (axi.arready) state_d = R;
      end
      R: begin
        rready_d = 1'b1;
        if (axi.rvalid) begin
          rdata_d   = axi.rdata;
          err_d     = (axi.rresp != 2'b00);
          discard_d = 1'b0;
          state_d   = (discard_q || flush_i) ? IDLE : DONE;
        end else if (flush_i) begin
          discard_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // kseg0/kseg1 both fold onto the low 512 MB physical window.
  assign axi.araddr  = {3'b000, addr_q[28:0]};
  assign axi.arid    = AR_ID;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = arvalid_d;
  assign axi.rready  = rready_d;

  // Stall depends only on state so the controller's stall->enable path
  // cannot close a combinational loop through this block.
  assign stallreq_o      = (state_q != DONE);
  assign bus_err_o       = (state_q == DONE) && err_q;
  assign inst_sram_rdata = rdata_q;

  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_en, inst_sram_wen, inst_sram_wdata,
                           axi.rid, axi.rlast, addr_q[31:29]};

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Scoreboard bench: each fetch is expanded into a cycle timeline of expected
// outputs that a negedge monitor pops and compares against the bridge.
module tb_inst_axi_rd_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        inst_sram_en = 1'b0;
  logic [31:0] inst_sram_addr = '0;
  logic [3:0]  inst_sram_wen = '0;
  logic [31:0] inst_sram_wdata = '0;
  logic [31:0] inst_sram_rdata;
  logic        stallreq_o;
  logic        bus_err_o;

  inst_axi_rd_bridge_if #(.ID_W(4)) axi ();

  inst_axi_rd_bridge #(.ID_W(4), .AR_ID(4'd0)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush_i),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .stallreq_o      (stallreq_o),
    .bus_err_o       (bus_err_o),
    .axi             (axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        arvalid;
    logic        rready;
    logic        stall;
    logic        err;
    logic        done;
    logic [31:0] araddr;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cycle  = 0;
  logic mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
  endtask

  // Monitor: one expected entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_on && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stallreq", {31'd0, stallreq_o}, {31'd0, e.stall});
      chk("arvalid",  {31'd0, axi.arvalid}, {31'd0, e.arvalid});
      chk("rready",   {31'd0, axi.rready}, {31'd0, e.rready});
      chk("bus_err",  {31'd0, bus_err_o}, {31'd0, e.err});
      if (e.arvalid) begin
        chk("araddr",  axi.araddr, e.araddr);
        chk("arlen",   {24'd0, axi.arlen}, 32'd0);
        chk("arsize",  {29'd0, axi.arsize}, 32'd2);
        chk("arburst", {30'd0, axi.arburst}, 32'd1);
        chk("arid",    {28'd0, axi.arid}, 32'd0);
      end
      if (e.done) chk("inst_rdata", inst_sram_rdata, e.rdata);
      cycle++;
    end
  end

  task automatic cyc(input logic fl, input logic [31:0] ad, input logic ard,
                     input logic rv, input logic [31:0] rd, input logic [1:0] rr,
                     input exp_t e);
    flush_i         = fl;
    inst_sram_addr  = ad;
    inst_sram_en    = 1'($urandom);
    inst_sram_wen   = 4'd0;
    inst_sram_wdata = $urandom;
    axi.arready     = ard;
    axi.rvalid      = rv;
    axi.rdata       = rd;
    axi.rresp       = rr;
    axi.rid         = 4'($urandom);
    axi.rlast       = 1'($urandom);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // One fetch: nfl flushed idle cycles, launch, AR with arw wait cycles,
  // R with rw wait cycles, then DONE unless flushed at index flpos of AR/R.
  task automatic fetch(input logic [31:0] addr, input int nfl, input int arw,
                       input int rw, input int flpos, input logic [31:0] rd,
                       input logic [1:0] rr);
    exp_t base, e;
    int   k;
    base = '{arvalid: 1'b0, rready: 1'b0, stall: 1'b1, err: 1'b0, done: 1'b0,
             araddr: 32'd0, rdata: 32'd0};
    for (int i = 0; i < nfl; i++) cyc(1'b1, $urandom, 1'b0, 1'b0, $urandom, 2'd0, base);
    cyc(1'b0, addr, 1'b0, 1'b0, $urandom, 2'd0, base);
    k = 0;
    for (int i = 0; i <= arw; i++) begin
      e = base;
      e.arvalid = 1'b1;
      e.araddr  = {3'b000, addr[28:0]};
      cyc(k == flpos, $urandom, i == arw, 1'b0, $urandom, 2'd0, e);
      k++;
    end
    for (int i = 0; i <= rw; i++) begin
      e = base;
      e.rready = 1'b1;
      cyc(k == flpos, $urandom, 1'b0, i == rw, (i == rw) ? rd : $urandom,
          (i == rw) ? rr : 2'($urandom), e);
      k++;
    end
    if (flpos < 0) begin
      e = base;
      e.stall = 1'b0;
      e.done  = 1'b1;
      e.rdata = rd;
      e.err   = (rr != 2'b00);
      cyc(1'($urandom), $urandom, 1'b0, 1'b0, $urandom, 2'($urandom), e);
    end
  endtask

  initial begin
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = '0;
    axi.rid     = '0;
    axi.rlast   = 1'b0;
    @(negedge clk);
    chk("rst_stall",   {31'd0, stallreq_o}, 32'd1);
    chk("rst_arvalid", {31'd0, axi.arvalid}, 32'd0);
    chk("rst_rready",  {31'd0, axi.rready}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err_o}, 32'd0);
    chk("rst_rdata",   inst_sram_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_on = 1'b1;

    // Boot fetch, minimum latency: DONE at cycle 3.
    fetch(32'hBFC0_0000, 0, 0, 0, -1, 32'h3C1D_BFC0, 2'b00);
    // arready held low 5 cycles.
    fetch(32'hBFC0_0004, 0, 5, 0, -1, 32'h1234_5678, 2'b00);
    // Flush in R with rvalid delayed 3 cycles, then new address.
    fetch(32'hBFC0_0008, 0, 0, 3, 2, 32'hAAAA_5555, 2'b00);
    fetch(32'h8000_0180, 0, 0, 0, -1, 32'h0000_0180, 2'b00);
    // Flush in the AR handshake cycle.
    fetch(32'h8000_0200, 0, 2, 1, 2, 32'h5555_AAAA, 2'b00);
    // Error response.
    fetch(32'h8000_0204, 0, 0, 0, -1, 32'hDEAD_BEEF, 2'b10);
    // Back-to-back sequential fetches.
    for (int i = 0; i < 3; i++)
      fetch(32'hBFC0_0100 + 32'(4 * i), 0, 0, 0, -1, 32'h0100_0000 + 32'(i), 2'b00);
    // Idle-cycle flush.
    fetch(32'h9FC0_0010, 2, 1, 1, -1, 32'hCAFE_F00D, 2'b11);

    for (int t = 0; t < 150; t++) begin
      int arw, rw, flpos;
      arw   = $urandom_range(0, 3);
      rw    = $urandom_range(0, 3);
      flpos = ($urandom_range(0, 3) == 0) ? $urandom_range(0, arw + rw) : -1;
      fetch($urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) * $urandom_range(0, 2),
            arw, rw, flpos, $urandom, 2'($urandom));
    end

    @(negedge clk);
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
